// File: rtl/fifo_bus_master_pkg.sv
// Shared definitions for the command FIFO / bus master slice: command
// field positions, the command record and the master FSM state encoding.
package fifo_bus_master_pkg;

    // Command word layout as presented at the FIFO head
    localparam int CMD_W   = 41;
    localparam int WE_BIT  = 40;
    localparam int ADDR_HI = 39;
    localparam int ADDR_LO = 32;
    localparam int DATA_HI = 31;
    localparam int DATA_LO = 0;
    localparam int ADDR_W  = ADDR_HI - ADDR_LO + 1;
    localparam int DATA_W  = DATA_HI - DATA_LO + 1;
    localparam int WAIT_W  = 8;

    // Master FSM states
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    // Decoded command record
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    // Split a raw FIFO word into its command fields
    function automatic cmd_t unpack_cmd(input logic [CMD_W-1:0] raw);
        cmd_t c;
        c.we    = raw[WE_BIT];
        c.addr  = raw[ADDR_HI:ADDR_LO];
        c.wdata = raw[DATA_HI:DATA_LO];
        return c;
    endfunction

    // Increment an 8-bit count, sticking at all-ones
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'hFF) begin
            r = v;
        end else begin
            r = v + 8'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_bus_master.sv
// Pops commands from a FIFO head and issues them one at a time on a simple
// req/ack bus. Reads return a one-cycle response strobe; a command that is
// not acknowledged within TIMEOUT request cycles is dropped with an err
// strobe and counted in a saturating error counter.
module fifo_bus_master
    import fifo_bus_master_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CMD_W-1:0]  fifo_data,
    input  logic              fifo_empty,
    output logic              fifo_rd,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              err,
    output logic [7:0]        err_count
);

    // Last wait-counter value before the request is abandoned
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_t              state_r;
    state_t              state_next_s;
    logic [WAIT_W-1:0]   wait_r;
    cmd_t                cmd_r;
    logic                rsp_valid_r;
    logic [DATA_W-1:0]   rsp_data_r;
    logic                err_r;
    logic [7:0]          err_count_r;
    logic                pop_s;
    logic                ack_s;
    logic                timeout_s;

    // Next-state decode; ack is checked before the timeout so it wins a tie
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        ack_s        = 1'b0;
        timeout_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty && !rst) begin
                    pop_s        = 1'b1;
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus_ack) begin
                    ack_s        = 1'b1;
                    state_next_s = ST_IDLE;
                end else if (wait_r == WAIT_LAST) begin
                    timeout_s    = 1'b1;
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Request-cycle counter: cleared on pop, counts unacknowledged REQ cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_r <= {WAIT_W{1'b0}};
        end else if (pop_s) begin
            wait_r <= {WAIT_W{1'b0}};
        end else if ((state_r == ST_REQ) && !ack_s && !timeout_s) begin
            wait_r <= wait_r + WAIT_W'(1);
        end else begin
            wait_r <= wait_r;
        end
    end

    // Command latch: FIFO head is captured only in the pop cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_r <= '0;
        end else if (pop_s) begin
            cmd_r <= unpack_cmd(fifo_data);
        end else begin
            cmd_r <= cmd_r;
        end
    end

    // Read response: one-cycle strobe, data held between reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= {DATA_W{1'b0}};
        end else if (ack_s && !cmd_r.we) begin
            rsp_valid_r <= 1'b1;
            rsp_data_r  <= bus_rdata;
        end else begin
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= rsp_data_r;
        end
    end

    // Timeout strobe and saturating timeout count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r       <= 1'b0;
            err_count_r <= 8'd0;
        end else if (timeout_s) begin
            err_r       <= 1'b1;
            err_count_r <= sat_inc8(err_count_r);
        end else begin
            err_r       <= 1'b0;
            err_count_r <= err_count_r;
        end
    end

    assign fifo_rd   = pop_s;
    assign bus_req   = (state_r == ST_REQ);
    assign bus_we    = cmd_r.we;
    assign bus_addr  = cmd_r.addr;
    assign bus_wdata = cmd_r.wdata;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign err       = err_r;
    assign err_count = err_count_r;

endmodule

// File: tb/tb_fifo_bus_master.sv
// Bench for fifo_bus_master: a queue-based FIFO, a bus slave with a chosen
// ack latency per command, and a transaction-level model of what the
// master must show on every cycle.
module tb_fifo_bus_master;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [40:0] fifo_data;
    logic        fifo_empty;
    logic        fifo_rd;
    logic        bus_req;
    logic        bus_we;
    logic [7:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        err;
    logic [7:0]  err_count;

    always #5 clk = ~clk;

    fifo_bus_master #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_rd    (fifo_rd),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .err        (err),
        .err_count  (err_count)
    );

    // Reference model: pending FIFO entries, the command on the bus and
    // how many request cycles it has had, plus expected strobes.
    logic [40:0] fifo_q[$];
    bit          m_busy;
    int          m_age;
    int          m_lat;
    logic [40:0] m_cmd;
    logic        m_rsp_valid;
    logic [31:0] m_rsp_data;
    logic        m_err;
    int          m_err_count;

    int          force_lat;
    bit          use_fixed_rdata;
    logic [31:0] fixed_rdata;

    int          obs_rd;
    int          obs_req;
    int          obs_rsp;
    int          obs_err;
    logic [31:0] last_rsp;

    int          n_err = 0;
    int          n_chk = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic clear_obs();
        obs_rd  = 0;
        obs_req = 0;
        obs_rsp = 0;
        obs_err = 0;
    endtask

    task automatic push_cmd(input logic we, input logic [7:0] addr, input logic [31:0] wdata);
        fifo_q.push_back({we, addr, wdata});
    endtask

    // One clock cycle: check outputs, drive inputs, then advance the model
    task automatic run_cycle();
        @(negedge clk);
        check_eq("bus_req", 32'(bus_req), 32'(m_busy));
        if (m_busy) begin
            check_eq("bus_we", 32'(bus_we), 32'(m_cmd[40]));
            check_eq("bus_addr", 32'(bus_addr), 32'(m_cmd[39:32]));
            check_eq("bus_wdata", bus_wdata, m_cmd[31:0]);
        end
        check_eq("rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
        check_eq("rsp_data", rsp_data, m_rsp_data);
        check_eq("err", 32'(err), 32'(m_err));
        check_eq("err_count", 32'(err_count), 32'(m_err_count));
        if (bus_req)   obs_req++;
        if (rsp_valid) begin obs_rsp++; last_rsp = rsp_data; end
        if (err)       obs_err++;

        fifo_empty = (fifo_q.size() == 0);
        if (fifo_q.size() != 0) fifo_data = fifo_q[0];
        else fifo_data = {1'($urandom), 8'($urandom), 32'($urandom)};
        if (m_busy) bus_ack = (m_age == m_lat);
        else bus_ack = ($urandom_range(0, 1) == 1);
        bus_rdata = use_fixed_rdata ? fixed_rdata : 32'($urandom);

        #1;
        check_eq("fifo_rd", 32'(fifo_rd), 32'(!m_busy && (fifo_q.size() != 0)));
        if (fifo_rd) obs_rd++;

        @(posedge clk);
        m_rsp_valid = 1'b0;
        m_err       = 1'b0;
        if (m_busy) begin
            if (bus_ack) begin
                m_busy = 1'b0;
                if (!m_cmd[40]) begin
                    m_rsp_valid = 1'b1;
                    m_rsp_data  = bus_rdata;
                end
            end else if (m_age + 1 == TO) begin
                m_busy = 1'b0;
                m_err  = 1'b1;
                if (m_err_count < 255) m_err_count++;
            end else begin
                m_age++;
            end
        end else if (fifo_q.size() != 0) begin
            m_cmd  = fifo_q.pop_front();
            m_busy = 1'b1;
            m_age  = 0;
            m_lat  = (force_lat >= 0) ? force_lat : $urandom_range(0, 5);
        end
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    task automatic model_reset();
        m_busy      = 1'b0;
        m_age       = 0;
        m_lat       = 0;
        m_cmd       = '0;
        m_rsp_valid = 1'b0;
        m_rsp_data  = 32'd0;
        m_err       = 1'b0;
        m_err_count = 0;
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_bus_req"},   32'(bus_req), 32'd0);
        check_eq({tag, "_fifo_rd"},   32'(fifo_rd), 32'd0);
        check_eq({tag, "_bus_we"},    32'(bus_we), 32'd0);
        check_eq({tag, "_bus_addr"},  32'(bus_addr), 32'd0);
        check_eq({tag, "_bus_wdata"}, bus_wdata, 32'd0);
        check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check_eq({tag, "_rsp_data"},  rsp_data, 32'd0);
        check_eq({tag, "_err"},       32'(err), 32'd0);
        check_eq({tag, "_err_count"}, 32'(err_count), 32'd0);
    endtask

    initial begin
        rst             = 1'b1;
        fifo_empty      = 1'b0;
        fifo_data       = {1'b1, 8'hAA, 32'h5555_5555};
        bus_ack         = 1'b0;
        bus_rdata       = 32'd0;
        force_lat       = -1;
        use_fixed_rdata = 1'b0;
        fixed_rdata     = 32'd0;
        last_rsp        = 32'd0;
        model_reset();
        clear_obs();

        // Reset state, with a non-empty FIFO that must not be popped
        #7;
        check_reset_values("rst");
        @(posedge clk);
        fifo_empty = 1'b1;
        #2 rst = 1'b0;

        // Write, ack after 3 waiting cycles
        clear_obs();
        force_lat = 3;
        push_cmd(1'b1, 8'h12, 32'hDEAD_BEEF);
        run_n(7);
        check_eq("wr_pops", 32'(obs_rd), 32'd1);
        check_eq("wr_req_cycles", 32'(obs_req), 32'd4);
        check_eq("wr_rsp", 32'(obs_rsp), 32'd0);

        // Read acked on first REQ cycle, next entry popped right after
        clear_obs();
        force_lat = 0;
        use_fixed_rdata = 1'b1;
        fixed_rdata = 32'hCAFE_F00D;
        push_cmd(1'b0, 8'h34, 32'($urandom));
        push_cmd(1'b1, 8'h56, 32'h0123_4567);
        run_n(3);
        check_eq("rd_next_pop", 32'(obs_rd), 32'd2);
        run_n(3);
        check_eq("rd_rsp_count", 32'(obs_rsp), 32'd1);
        check_eq("rd_rsp_data", last_rsp, 32'hCAFE_F00D);
        use_fixed_rdata = 1'b0;

        // Never acked: times out after TO request cycles
        clear_obs();
        force_lat = 99;
        push_cmd(1'b1, 8'h77, 32'h1111_2222);
        run_n(7);
        check_eq("to_req_cycles", 32'(obs_req), 32'(TO));
        check_eq("to_err_pulses", 32'(obs_err), 32'd1);
        check_eq("to_err_count", 32'(err_count), 32'd1);

        // Ack on the last allowed cycle wins over the timeout
        clear_obs();
        force_lat = TO - 1;
        push_cmd(1'b0, 8'h9A, 32'd0);
        run_n(7);
        check_eq("tie_err_pulses", 32'(obs_err), 32'd0);
        check_eq("tie_rsp", 32'(obs_rsp), 32'd1);

        // Back-to-back entries, immediate ack
        clear_obs();
        force_lat = 0;
        for (int i = 0; i < 6; i++) push_cmd(1'($urandom), 8'($urandom), 32'($urandom));
        run_n(13);
        check_eq("b2b_pops", 32'(obs_rd), 32'd6);
        check_eq("b2b_req_cycles", 32'(obs_req), 32'd6);

        // Many timeouts saturate the error counter
        clear_obs();
        force_lat = 99;
        for (int i = 0; i < 300; i++) push_cmd(1'($urandom), 8'($urandom), 32'($urandom));
        run_n(300 * (TO + 1) + 4);
        check_eq("sat_err_pulses", 32'(obs_err), 32'd300);
        check_eq("sat_err_count", 32'(err_count), 32'd255);

        // Reset in the middle of a request
        force_lat = 99;
        push_cmd(1'b0, 8'hBC, 32'h0);
        run_n(2);
        check_eq("mid_busy", 32'(bus_req), 32'd1);
        push_cmd(1'b1, 8'hCD, 32'h4444_5555);
        @(negedge clk);
        fifo_empty = 1'b0;
        fifo_data  = fifo_q[0];
        #2 rst = 1'b1;
        #1;
        check_reset_values("mid_rst");
        model_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        clear_obs();
        run_n(2);
        check_eq("mid_no_err", 32'(obs_err), 32'd0);
        check_eq("mid_no_rsp", 32'(obs_rsp), 32'd0);

        // Random traffic with random ack latencies and FIFO writes during REQ
        force_lat = -1;
        for (int i = 0; i < 500; i++) begin
            if (fifo_q.size() < 8 && $urandom_range(0, 1) == 1)
                push_cmd(1'($urandom), 8'($urandom), 32'($urandom));
            run_cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fifo_bus_master.md
FIFO_BUS_MASTER -- requirements
Module: fifo_bus_master

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the maximum number of cycles to wait for bus_ack (range 1..255).
REQ-002 clk  input  1  single clock; all logic SHALL be on posedge clk.
REQ-003 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-004 fifo_data  input  41  SHALL carry the head entry of the command FIFO: bit 40 = we (1 write, 0 read), bits 39:32 = addr, bits 31:0 = wdata.
REQ-005 fifo_empty  input  1  SHALL mean the FIFO holds no entry.
REQ-006 fifo_rd  output  1  SHALL be the FIFO read enable, one pulse per consumed entry.
REQ-007 bus_req  output  1  SHALL be the bus request, held until acknowledged or timed out.
REQ-008 bus_we / bus_addr / bus_wdata  output  1/8/32  SHALL be the latched command fields.
REQ-009 bus_ack  input  1  SHALL be the slave acknowledge; it is valid only while bus_req=1.
REQ-010 bus_rdata  input  32  SHALL be the read data, sampled with bus_ack.
REQ-011 rsp_valid / rsp_data  output  1/32  SHALL be a one-cycle read-response strobe and its data; there is no backpressure.
REQ-012 err  output  1  SHALL be a one-cycle timeout strobe.
REQ-013 err_count  output  8  SHALL be a saturating timeout counter.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE and REQ.
REQ-015 fifo_rd SHALL be combinational and equal (state==IDLE && !fifo_empty).
REQ-016 On a clock edge with fifo_rd=1, the block SHALL latch we, addr and wdata from fifo_data, clear the wait counter and enter REQ.
REQ-017 bus_req SHALL be 1 exactly while state==REQ; bus_we, bus_addr and bus_wdata SHALL remain stable throughout REQ.
REQ-018 In REQ with bus_ack=1, the block SHALL return to IDLE on that edge.
REQ-019 If the acknowledged command is a read, the block SHALL register bus_rdata into rsp_data and assert rsp_valid for the following cycle only.
REQ-020 For an acknowledged write, rsp_valid SHALL stay 0 and rsp_data SHALL hold its previous value.
REQ-021 In REQ without ack, the 8-bit wait counter SHALL increment each cycle.
REQ-022 When the wait counter equals TIMEOUT-1 without ack, the block SHALL go to IDLE on that edge, pulse err for the next cycle and increment err_count, saturating at 255.
REQ-023 If ack and timeout occur in the same cycle, ack SHALL win: no err pulse, and normal completion.
REQ-024 Minimum command spacing SHALL be 2 cycles (pop, then REQ with immediate ack); a new pop SHALL be allowed in the cycle after ack.
REQ-025 bus_ack received while in IDLE SHALL be ignored.
REQ-026 fifo_data SHALL be sampled only in the pop cycle; FIFO writes during REQ SHALL not affect the active command.

Reset
REQ-027 Asserting rst SHALL asynchronously force: state IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, rsp_valid=0, rsp_data=0, err=0, err_count=0, wait counter 0.
REQ-028 A reset during REQ SHALL abandon the active command without an err pulse or a response; the entry already popped is lost.
REQ-029 fifo_rd SHALL be 0 while rst=1.

Structure
REQ-030 Field positions (WE_BIT=40, ADDR 39:32, DATA 31:0), the 41-bit command width and the state encoding SHALL live in the shared package, which fifo_sync users also import.
REQ-031 The design SHALL be a single module with no sub-modules; the wait counter and FSM are inline.

Verification
REQ-032 Write {1,0x12,0xDEADBEEF}, ack after 3 cycles -> exactly one fifo_rd pulse, bus_req high 4 cycles with addr 0x12 and wdata 0xDEADBEEF, no rsp_valid.
REQ-033 Read {0,0x34,x}, ack with rdata 0xCAFEF00D on the first REQ cycle -> rsp_valid for 1 cycle with rsp_data 0xCAFEF00D, next pop allowed the following cycle.
REQ-034 TIMEOUT=4, never ack -> bus_req high exactly 4 cycles, err pulses once, err_count=1; 300 such timeouts -> err_count=255.
REQ-035 TIMEOUT=4, ack on the 4th REQ cycle -> no err pulse, normal completion.
REQ-036 rst asserted mid-REQ -> bus_req drops before the next edge, all outputs at reset values, no err or rsp pulse.
REQ-037 Back-to-back FIFO entries with immediate ack -> one command per 2 cycles, fields in FIFO order, no fifo_rd while in REQ.
